// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared constants and FSM state encoding for the
// instruction/data memory bus arbiter.
//   RST_ENABLE  - level of rst that holds the block in reset
//   CHIP_ENABLE - level of a port ce input that requests an access
//   ZERO_WORD   - 32-bit zero used for reset and unused write data
//   arb_state_e - IDLE / D_BUSY / I_BUSY, 2-bit encoding
package mem_bus_arbiter_pkg;

  localparam logic        RST_ENABLE  = 1'b1;
  localparam logic        CHIP_ENABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_D_BUSY = 2'b01,
    ARB_I_BUSY = 2'b10
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one cyc/stb/ack memory bus between the fetch port
// and the MEM-stage data port. Each port gets at most one bus transaction per
// pipeline step; the data port wins when both request in the same cycle.
// Ports:
//   clk, rst                 - clock, async active-high reset
//   if_*                     - fetch request, address, captured word, stall
//   dm_*                     - data request/we/sel/addr/wdata, raw load word, stall
//   pipe_stall_i             - pipeline held by some other stall source
//   flush_i                  - exception flush, clears per-step done flags
//   bus_*                    - registered bus master outputs, rdata/ack inputs
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_ce_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_stall_req_o,
  input  logic        dm_ce_i,
  input  logic        dm_we_i,
  input  logic [3:0]  dm_sel_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_stall_req_o,
  input  logic        pipe_stall_i,
  input  logic        flush_i,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i
);

  arb_state_e state;
  logic       d_done, i_done;
  // Set when a flush lands while a transaction is in flight, so that the
  // eventual ack still captures data but does not mark the port done.
  logic       xfer_flushed;
  logic       dm_req, if_req, advance;

  assign dm_req  = (dm_ce_i == CHIP_ENABLE) & ~d_done;
  assign if_req  = (if_ce_i == CHIP_ENABLE) & ~i_done;
  assign dm_stall_req_o = dm_req;
  assign if_stall_req_o = if_req;
  assign advance = ~pipe_stall_i & ~dm_req & ~if_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      state        <= ARB_IDLE;
      d_done       <= 1'b0;
      i_done       <= 1'b0;
      xfer_flushed <= 1'b0;
      bus_cyc_o    <= 1'b0;
      bus_stb_o    <= 1'b0;
      bus_we_o     <= 1'b0;
      bus_sel_o    <= 4'b0000;
      bus_addr_o   <= ZERO_WORD;
      bus_wdata_o  <= ZERO_WORD;
      if_rdata_o   <= ZERO_WORD;
      dm_rdata_o   <= ZERO_WORD;
    end else begin
      // Step boundary or flush: forget completed accesses. An ack in the
      // same cycle (below) overrides only when no flush is present.
      if (flush_i | advance) begin
        d_done <= 1'b0;
        i_done <= 1'b0;
      end

      case (state)
        ARB_IDLE: begin
          xfer_flushed <= 1'b0;
          // Issue decision uses the flags as they stand this cycle, so a
          // flush arriving in IDLE does not suppress a pending issue.
          if (dm_req) begin
            state       <= ARB_D_BUSY;
            bus_cyc_o   <= 1'b1;
            bus_stb_o   <= 1'b1;
            bus_we_o    <= dm_we_i;
            bus_sel_o   <= dm_sel_i;
            bus_addr_o  <= dm_addr_i;
            bus_wdata_o <= dm_wdata_i;
          end else if (if_req) begin
            state       <= ARB_I_BUSY;
            bus_cyc_o   <= 1'b1;
            bus_stb_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'b1111;
            bus_addr_o  <= if_addr_i;
            bus_wdata_o <= ZERO_WORD;
          end
        end

        ARB_D_BUSY: begin
          if (flush_i) xfer_flushed <= 1'b1;
          if (bus_ack_i) begin
            dm_rdata_o <= bus_rdata_i;
            if (!flush_i && !xfer_flushed) d_done <= 1'b1;
            bus_cyc_o  <= 1'b0;
            bus_stb_o  <= 1'b0;
            state      <= ARB_IDLE;
          end
        end

        ARB_I_BUSY: begin
          if (flush_i) xfer_flushed <= 1'b1;
          if (bus_ack_i) begin
            if_rdata_o <= bus_rdata_i;
            if (!flush_i && !xfer_flushed) i_done <= 1'b1;
            bus_cyc_o  <= 1'b0;
            bus_stb_o  <= 1'b0;
            state      <= ARB_IDLE;
          end
        end

        default: begin
          state     <= ARB_IDLE;
          bus_cyc_o <= 1'b0;
          bus_stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
